vga_color_pipe: RTL and testbench
=================================

# vga_color_pipe

Registered, parametrised VGA colour output stage. It replaces the combinational colour expander between the pixel source and the VGA pins. It adds four output modes (pass, invert, grayscale, colour bars), frame-synchronous mode switching, and sync signals delayed so they stay cycle-aligned with the colour data. It sits directly after the sync/timing generator and drives the board's VGA DAC pins.

## Interface
Parameters:
- CH_BITS, 3: input bits per colour channel.
- OUT_BITS, 8: output bits per channel. Must satisfy OUT_BITS ≥ CH_BITS.
- H_VISIBLE, 640: visible pixels per line, used for colour-bar width. Must be a multiple of 8.

Ports:
- clk  in  1  pixel clock. One clock domain only.
- rst  in  1  reset, asynchronous, active-high.
- color  in  3*CH_BITS  pixel colour, packed {R, G, B}, R in the MSBs.
- h_sync  in  1  horizontal sync from the timing generator, active-low.
- v_sync  in  1  vertical sync from the timing generator, active-low.
- video_on  in  1  high in the visible area.
- mode_req  in  2  requested mode: 0 = pass, 1 = invert, 2 = grayscale, 3 = colour bars.
- mode_load  in  1  single-cycle strobe that captures mode_req.
- vga_r, vga_g, vga_b  out  OUT_BITS each  colour to the DAC.
- vga_hs, vga_vs  out  1  delayed syncs.
- mode_active  out  2  mode currently applied.

## Operation
Mode shadowing:
- mode_load=1 writes mode_req into the pending register. If several loads arrive in one frame, the last one wins.
- Frame edge = v_sync 1→0, detected against a registered copy of v_sync.
- On a frame edge, the active mode takes the pending value as it stood before that cycle.
- A mode_load in the same cycle as the edge is applied at the next frame edge.
- mode_active never changes except at a frame edge.

Per-pixel modes (stage 1), all in CH_BITS per channel:
- Pass: channels unchanged.
- Invert: each channel bitwise NOT.
- Grayscale: sum = R + 2G + B, computed in CH_BITS+2 bits. gray = sum >> 2, applied to all three channels.
- Bars: col counter increments on each video_on=1 cycle and clears when video_on=0.
  - Bar index = col / (H_VISIBLE/8), saturating at 7.
  - Bars in order: white, yellow, cyan, green, magenta, red, blue, black.
  - Each bar channel is either all-ones or all-zeros.
  - The color input is ignored in this mode.

Expansion (stage 2):
- Replicate each channel MSB-first to fill OUT_BITS: out[OUT_BITS-1-i] = ch[CH_BITS-1-(i mod CH_BITS)].
- Examples: 3'b101 → 8'hB6; all-ones → all-ones.

Blanking:
- When the video_on delayed alongside the pixel is 0, all colour outputs are 0.
- The bar counter still clears while blanked.

## Timing
- Fixed latency of 2 cycles from the input to all of vga_r/g/b, vga_hs, vga_vs.
- The syncs go through the same 2 stages, so colour and syncs stay aligned with no skew.
- mode_active updates in the cycle after the clock edge that samples the frame edge.
- The new mode takes effect on the pixel sampled in that same cycle.
- Reset, asynchronous and immediate, sets:
  - vga_r/g/b = 0.
  - vga_hs = vga_vs = 1 (idle).
  - mode_active = 0, pending = 0, col = 0.
  - Pipeline video_on bits = 0.
  - Stored previous v_sync = 1, so no spurious frame edge occurs after reset.
- Reset mid-frame discards in-flight pixels. The first valid output appears 2 cycles after rst deasserts.
- col saturates at its maximum value rather than wrapping, for lines longer than H_VISIBLE.
- No backpressure: one pixel is accepted and one produced every cycle.

## Structure
- Shared package vga_pkg holds:
  - Mode constants MODE_PASS, MODE_INV, MODE_GRAY, MODE_BARS.
  - Bar colour table: 8 entries × 3 one-bit flags (channel on/off).
- Sub-module vga_bit_expand (parameters CH_BITS, OUT_BITS): combinational replication, instantiated once per channel.
- Everything else stays in vga_color_pipe: mode registers, edge detect, col counter, the two pipeline stages.

## Test plan
- Reset mid-line with rst=1 → vga_r/g/b=0, vga_hs=vga_vs=1, mode_active=0 in the same cycle. After release, the first pixel appears at the outputs 2 cycles later.
- Pass mode, color={3'b101, 3'b011, 3'b000}, video_on=1 → 2 cycles later vga_r=8'hB6, vga_g=8'h6D, vga_b=8'h00. Syncs toggled at the input show up on the same cycle.
- video_on=0 with color all-ones → outputs 0. vga_hs/vga_vs equal the inputs delayed by 2 cycles.
- mode_load with mode_req=1 mid-frame → mode_active stays 0 until the v_sync falling edge, then becomes 1. Pixel {7,0,0} then gives 8'h00, 8'hFF, 8'hFF. A load on the edge cycle itself is applied only at the following frame.
- Grayscale with R=7, G=7, B=0 → (7+14+0)>>2 = 5, so all channels are 8'hB6.
- Bars, H_VISIBLE=640, one full line:
  - Pixels 0–79 → FF/FF/FF.
  - Pixels 80–159 → FF/FF/00.
  - Pixels 560–639 → 00/00/00.
  - After blanking, col restarts and the next line's pixel 0 is white.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA colour output stage: output modes and the
// colour-bar palette.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_INV  = 2'd1,
        MODE_GRAY = 2'd2,
        MODE_BARS = 2'd3
    } mode_e;

    // {R,G,B} on/off flags, bar 0 at the left edge of the screen
    localparam logic [2:0] BAR_TABLE [8] = '{
        3'b111, 3'b110, 3'b011, 3'b010,
        3'b101, 3'b100, 3'b001, 3'b000
    };

endpackage

// File: rtl/vga_bit_expand.sv
// Widens one colour channel by repeating its bits MSB-first, so full scale
// maps to full scale and zero to zero.
module vga_bit_expand #(
    parameter int CH_BITS  = 3,
    parameter int OUT_BITS = 8
) (
    input  logic [CH_BITS-1:0]  ch_i,
    output logic [OUT_BITS-1:0] exp_o
);

    for (genvar i = 0; i < OUT_BITS; i++) begin : g_rep
        assign exp_o[OUT_BITS-1-i] = ch_i[CH_BITS-1-(i % CH_BITS)];
    end

endmodule

// File: rtl/vga_color_pipe.sv
// Two-stage registered colour path between the timing generator and the VGA
// DAC, with frame-synchronous mode switching and syncs delayed to match.
module vga_color_pipe
    import vga_pkg::*;
#(
    parameter int CH_BITS   = 3,
    parameter int OUT_BITS  = 8,
    parameter int H_VISIBLE = 640
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3*CH_BITS-1:0]   color,
    input  logic                   h_sync,
    input  logic                   v_sync,
    input  logic                   video_on,
    input  logic [1:0]             mode_req,
    input  logic                   mode_load,
    output logic [OUT_BITS-1:0]    vga_r,
    output logic [OUT_BITS-1:0]    vga_g,
    output logic [OUT_BITS-1:0]    vga_b,
    output logic                   vga_hs,
    output logic                   vga_vs,
    output logic [1:0]             mode_active
);

    localparam int COL_W = $clog2(H_VISIBLE) + 1;
    localparam int BAR_W = H_VISIBLE / 8;

    function automatic logic [COL_W-1:0] col_next(input logic [COL_W-1:0] col);
        return (col == {COL_W{1'b1}}) ? col : col + COL_W'(1);
    endfunction

    function automatic logic [2:0] bar_index(input logic [COL_W-1:0] col);
        logic [COL_W-1:0] idx;
        idx = col / COL_W'(BAR_W);
        return (idx > COL_W'(7)) ? 3'd7 : idx[2:0];
    endfunction

    mode_e              mode_active_q;
    mode_e              pending_q;
    logic               vs_prev_q;
    logic [COL_W-1:0]   col_q;
    logic [COL_W-1:0]   col_d;
    logic               frame_edge;

    logic [CH_BITS-1:0] r_in, g_in, b_in;
    logic [CH_BITS+1:0] gray_sum;
    logic [2:0]         bar_rgb;
    logic [CH_BITS-1:0] r_d, g_d, b_d;

    logic [CH_BITS-1:0] r_p1_q, g_p1_q, b_p1_q;
    logic               vld_p1_q, hs_p1_q, vs_p1_q;

    logic [OUT_BITS-1:0] exp_r, exp_g, exp_b;
    logic [OUT_BITS-1:0] r_p2_d, g_p2_d, b_p2_d;
    logic [OUT_BITS-1:0] r_p2_q, g_p2_q, b_p2_q;
    logic                hs_p2_q, vs_p2_q;

    assign {r_in, g_in, b_in} = color;
    assign frame_edge = vs_prev_q & ~v_sync;
    assign col_d      = video_on ? col_next(col_q) : '0;
    assign gray_sum   = {2'b00, r_in} + {1'b0, g_in, 1'b0} + {2'b00, b_in};
    assign bar_rgb    = BAR_TABLE[bar_index(col_q)];

    always_comb begin
        r_d = r_in;
        g_d = g_in;
        b_d = b_in;
        unique case (mode_active_q)
            MODE_INV: begin
                r_d = ~r_in;
                g_d = ~g_in;
                b_d = ~b_in;
            end
            MODE_GRAY: begin
                r_d = gray_sum[CH_BITS+1:2];
                g_d = gray_sum[CH_BITS+1:2];
                b_d = gray_sum[CH_BITS+1:2];
            end
            MODE_BARS: begin
                r_d = {CH_BITS{bar_rgb[2]}};
                g_d = {CH_BITS{bar_rgb[1]}};
                b_d = {CH_BITS{bar_rgb[0]}};
            end
            default: ;
        endcase
    end

    // Stage 1: mode processing, pixel data needs no reset
    always_ff @(posedge clk) begin
        r_p1_q <= r_d;
        g_p1_q <= g_d;
        b_p1_q <= b_d;
    end

    vga_bit_expand #(.CH_BITS(CH_BITS), .OUT_BITS(OUT_BITS)) u_exp_r (.ch_i(r_p1_q), .exp_o(exp_r));
    vga_bit_expand #(.CH_BITS(CH_BITS), .OUT_BITS(OUT_BITS)) u_exp_g (.ch_i(g_p1_q), .exp_o(exp_g));
    vga_bit_expand #(.CH_BITS(CH_BITS), .OUT_BITS(OUT_BITS)) u_exp_b (.ch_i(b_p1_q), .exp_o(exp_b));

    assign r_p2_d = vld_p1_q ? exp_r : '0;
    assign g_p2_d = vld_p1_q ? exp_g : '0;
    assign b_p2_d = vld_p1_q ? exp_b : '0;

    // Stage 2: expansion and blanking; control and outputs reset to idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_active_q <= MODE_PASS;
            pending_q     <= MODE_PASS;
            vs_prev_q     <= 1'b1;
            col_q         <= '0;
            vld_p1_q      <= 1'b0;
            hs_p1_q       <= 1'b1;
            vs_p1_q       <= 1'b1;
            r_p2_q        <= '0;
            g_p2_q        <= '0;
            b_p2_q        <= '0;
            hs_p2_q       <= 1'b1;
            vs_p2_q       <= 1'b1;
        end else begin
            if (frame_edge) mode_active_q <= pending_q;
            if (mode_load)  pending_q     <= mode_e'(mode_req);
            vs_prev_q <= v_sync;
            col_q     <= col_d;
            vld_p1_q  <= video_on;
            hs_p1_q   <= h_sync;
            vs_p1_q   <= v_sync;
            r_p2_q    <= r_p2_d;
            g_p2_q    <= g_p2_d;
            b_p2_q    <= b_p2_d;
            hs_p2_q   <= hs_p1_q;
            vs_p2_q   <= vs_p1_q;
        end
    end

    assign vga_r       = r_p2_q;
    assign vga_g       = g_p2_q;
    assign vga_b       = b_p2_q;
    assign vga_hs      = hs_p2_q;
    assign vga_vs      = vs_p2_q;
    assign mode_active = mode_active_q;

endmodule

// File: tb/tb_vga_color_pipe.sv
// Bench for vga_color_pipe: directed vectors and corner sequences plus random
// traffic compared against a cycle-level reference model.
module tb_vga_color_pipe;

    localparam int HV = 640;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] color = '0;
    logic       h_sync = 1'b1;
    logic       v_sync = 1'b1;
    logic       video_on = 1'b0;
    logic [1:0] mode_req = '0;
    logic       mode_load = 1'b0;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs;
    logic [1:0] mode_active;

    vga_color_pipe #(.CH_BITS(3), .OUT_BITS(8), .H_VISIBLE(HV)) dut (
        .clk(clk), .rst(rst), .color(color), .h_sync(h_sync), .v_sync(v_sync),
        .video_on(video_on), .mode_req(mode_req), .mode_load(mode_load),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .mode_active(mode_active)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] r, g, b;
        logic       hs, vs;
    } out_t;

    typedef struct {
        logic [8:0]  c;
        logic        von, hs, vs;
        logic [25:0] exp;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;

    out_t        m_p1, m_out;
    int          m_active, m_pending, m_col;
    logic        m_vsprev;
    logic [23:0] bars [8];
    logic [23:0] line [HV];
    vec_t        vt [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] expand(input int v);
        logic [2:0] c;
        logic [8:0] rep;
        c = v[2:0];
        rep = {c, c, c};
        return rep[8:1];
    endfunction

    function automatic out_t model_pixel();
        out_t o;
        int r, g, b, gy, idx;
        r = int'(color[8:6]);
        g = int'(color[5:3]);
        b = int'(color[2:0]);
        if (m_active == 1) begin
            r = 7 - r; g = 7 - g; b = 7 - b;
        end else if (m_active == 2) begin
            gy = (r + 2 * g + b) / 4;
            r = gy; g = gy; b = gy;
        end
        o.r = expand(r);
        o.g = expand(g);
        o.b = expand(b);
        if (m_active == 3) begin
            idx = m_col / (HV / 8);
            if (idx > 7) idx = 7;
            {o.r, o.g, o.b} = bars[idx];
        end
        if (!video_on) {o.r, o.g, o.b} = '0;
        o.hs = h_sync;
        o.vs = v_sync;
        return o;
    endfunction

    task automatic model_reset();
        m_p1 = {24'h0, 2'b11};
        m_out = {24'h0, 2'b11};
        m_active = 0;
        m_pending = 0;
        m_col = 0;
        m_vsprev = 1'b1;
    endtask

    task automatic tick();
        out_t nxt;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            nxt = model_pixel();
            m_out = m_p1;
            m_p1 = nxt;
            if (m_vsprev && !v_sync) m_active = m_pending;
            if (mode_load) m_pending = int'(mode_req);
            m_vsprev = v_sync;
            m_col = video_on ? ((m_col < 2047) ? m_col + 1 : m_col) : 0;
        end
        #1;
        check("model", {vga_r, vga_g, vga_b, vga_hs, vga_vs, mode_active}, {m_out, 2'(m_active)});
    endtask

    task automatic drive(input logic [8:0] c, input logic von, input logic hs, input logic vs);
        color = c;
        video_on = von;
        h_sync = hs;
        v_sync = vs;
    endtask

    initial begin
        bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
        bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;

        vt[0] = '{9'b101_011_000, 1'b1, 1'b1, 1'b1, {8'hB6, 8'h6D, 8'h00, 2'b11}};
        vt[1] = '{9'b101_011_000, 1'b1, 1'b0, 1'b1, {8'hB6, 8'h6D, 8'h00, 2'b01}};
        vt[2] = '{9'b111_111_111, 1'b0, 1'b1, 1'b1, {8'h00, 8'h00, 8'h00, 2'b11}};
        vt[3] = '{9'b111_111_111, 1'b1, 1'b0, 1'b0, {8'hFF, 8'hFF, 8'hFF, 2'b00}};
        vt[4] = '{9'b000_111_001, 1'b1, 1'b1, 1'b1, {8'h00, 8'hFF, 8'h24, 2'b11}};
        vt[5] = '{9'b010_100_110, 1'b0, 1'b0, 1'b1, {8'h00, 8'h00, 8'h00, 2'b01}};
        vt[6] = '{9'b110_110_110, 1'b1, 1'b1, 1'b0, {8'hDB, 8'hDB, 8'hDB, 2'b10}};

        model_reset();
        tick();
        check("reset_state", {vga_r, vga_g, vga_b, vga_hs, vga_vs, mode_active}, {24'h0, 2'b11, 2'b00});
        tick();
        rst = 1'b0;
        tick();

        // Directed pass-mode vectors
        for (int j = 0; j <= 7; j++) begin
            if (j < 7) drive(vt[j].c, vt[j].von, vt[j].hs, vt[j].vs);
            tick();
            if (j >= 1)
                check($sformatf("vec%0d", j - 1), {vga_r, vga_g, vga_b, vga_hs, vga_vs}, vt[j-1].exp);
        end

        // Mode shadowing
        drive(9'h000, 1'b0, 1'b1, 1'b1);
        tick();
        mode_req = 2'd1;
        mode_load = 1'b1;
        tick();
        mode_load = 1'b0;
        check("mode_hold0", mode_active, 2'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mode_hold", mode_active, 2'd0);
        end
        drive(9'b111_000_000, 1'b1, 1'b1, 1'b0);
        mode_req = 2'd2;
        mode_load = 1'b1;
        tick();
        mode_load = 1'b0;
        check("mode_edge", mode_active, 2'd1);
        drive(9'b111_000_000, 1'b1, 1'b1, 1'b0);
        tick();
        check("pix_old_mode", {vga_r, vga_g, vga_b}, 24'hFF0000);
        drive(9'h000, 1'b0, 1'b1, 1'b0);
        tick();
        check("pix_inv", {vga_r, vga_g, vga_b}, 24'h00FFFF);
        check("edge_load_deferred", mode_active, 2'd1);
        drive(9'h000, 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        check("mode_still1", mode_active, 2'd1);
        drive(9'h000, 1'b0, 1'b1, 1'b0);
        tick();
        check("mode_next_frame", mode_active, 2'd2);

        // Grayscale
        drive(9'b111_111_000, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        check("gray", {vga_r, vga_g, vga_b}, 24'hB6B6B6);

        // Colour bars over one full line
        drive(9'h000, 1'b0, 1'b1, 1'b1);
        mode_req = 2'd3;
        mode_load = 1'b1;
        tick();
        mode_load = 1'b0;
        drive(9'h000, 1'b0, 1'b1, 1'b0);
        tick();
        check("mode_bars", mode_active, 2'd3);
        tick();
        for (int n = 0; n <= HV; n++) begin
            if (n < HV) drive(9'($urandom), 1'b1, 1'b1, 1'b0);
            else drive(9'h000, 1'b0, 1'b1, 1'b0);
            tick();
            if (n >= 1) line[n-1] = {vga_r, vga_g, vga_b};
        end
        check("bar_px0",   line[0],   24'hFFFFFF);
        check("bar_px79",  line[79],  24'hFFFFFF);
        check("bar_px80",  line[80],  24'hFFFF00);
        check("bar_px159", line[159], 24'hFFFF00);
        check("bar_px320", line[320], 24'hFF00FF);
        check("bar_px560", line[560], 24'h000000);
        check("bar_px639", line[639], 24'h000000);
        tick();
        tick();
        drive(9'h000, 1'b1, 1'b1, 1'b0);
        tick();
        drive(9'h000, 1'b0, 1'b1, 1'b0);
        tick();
        check("bar_next_line", {vga_r, vga_g, vga_b}, 24'hFFFFFF);

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            mode_load = ($urandom_range(0, 15) == 0);
            mode_req = 2'($urandom);
            drive(9'($urandom), $urandom_range(0, 63) != 0, $urandom_range(0, 99) != 0,
                  $urandom_range(0, 199) >= 8);
            tick();
        end
        mode_load = 1'b0;

        // Asynchronous reset in the middle of a line
        drive(9'h1FF, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        #3;
        rst = 1'b1;
        #1;
        check("rst_async", {vga_r, vga_g, vga_b, vga_hs, vga_vs, mode_active}, {24'h0, 2'b11, 2'b00});
        model_reset();
        tick();
        rst = 1'b0;
        drive(9'b101_011_000, 1'b1, 1'b1, 1'b1);
        tick();
        check("rst_lat1", {vga_r, vga_g, vga_b}, 24'h000000);
        drive(9'h000, 1'b0, 1'b1, 1'b1);
        tick();
        check("rst_first_pix", {vga_r, vga_g, vga_b}, 24'hB66D00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
